// File: rtl/bird_column.sv
// bird_column: single-column bird position engine for the LED-matrix game.
// It tracks the bird row, applies flap lift and tick-paced gravity, and
// detects floor and pipe collisions.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   flap_i       single-cycle flap pulse (debounced, edge-detected upstream)
//   tick_i       single-cycle game-tick pulse
//   pipe_mask_i  pipe occupancy of this column, bit i = row i
//   lit_o        one-hot bird position for the display column
//   row_o        registered bird row index (0 = bottom)
//   crashed_o    high while in DEAD
//   playing_o    high while in PLAY
//
// Optional feature macro: BIRD_CEILING_CRASH_EN
//   When defined, a flap in PLAY that would pass the top row clamps to the
//   top row and ends the game on the same edge. Otherwise it clamps silently.
module bird_column #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned START_ROW   = 4,
  parameter int unsigned FALL_TICKS  = 2,
  parameter int unsigned FLAP_HEIGHT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap_i,
  input  logic                    tick_i,
  input  logic [ROWS-1:0]         pipe_mask_i,
  output logic [ROWS-1:0]         lit_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic                    crashed_o,
  output logic                    playing_o
);

  localparam int unsigned RowW    = $clog2(ROWS);
  localparam int unsigned RowExtW = RowW + 1;
  localparam int unsigned CntW    = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

  localparam logic [RowW-1:0]    StartRow = RowW'(START_ROW);
  localparam logic [RowW-1:0]    TopRow   = RowW'(ROWS - 1);
  localparam logic [RowExtW-1:0] TopExt   = RowExtW'(ROWS - 1);
  localparam logic [CntW-1:0]    FallLast = CntW'(FALL_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StDead} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [CntW-1:0]   fall_cnt_q, fall_cnt_d;

  // One extra bit so the sum cannot wrap before it is clamped.
  logic [RowExtW-1:0] flap_sum;
  logic               flap_over;
  logic [RowW-1:0]    flap_row;

  always_comb begin
    flap_sum  = {1'b0, row_q} + RowExtW'(FLAP_HEIGHT);
    flap_over = (flap_sum > TopExt);
    flap_row  = flap_over ? TopRow : flap_sum[RowW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    fall_cnt_d = fall_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Ticks and pipes are ignored until the first flap; clamp is silent here.
        if (flap_i) begin
          state_d    = StPlay;
          row_d      = flap_row;
          fall_cnt_d = '0;
        end
      end
      StPlay: begin
        // Collision uses the current registered row and wins over everything.
        if (pipe_mask_i[row_q]) begin
          state_d = StDead;
        end else if (flap_i) begin
          // A same-cycle tick is discarded; gravity phase restarts.
          row_d      = flap_row;
          fall_cnt_d = '0;
`ifdef BIRD_CEILING_CRASH_EN
          if (flap_over) state_d = StDead;
`endif
        end else if (tick_i) begin
          if (fall_cnt_q != FallLast) begin
            fall_cnt_d = fall_cnt_q + 1'b1;
          end else begin
            fall_cnt_d = '0;
            if (row_q != '0) row_d = row_q - 1'b1;
            else             state_d = StDead;
          end
        end
      end
      StDead: begin
        if (flap_i) begin
          state_d    = StIdle;
          row_d      = StartRow;
          fall_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        row_d      = StartRow;
        fall_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      row_q      <= StartRow;
      fall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  // row_q is always < ROWS, so the decode is exactly one-hot.
  assign lit_o     = {{(ROWS-1){1'b0}}, 1'b1} << row_q;
  assign row_o     = row_q;
  assign crashed_o = (state_q == StDead);
  assign playing_o = (state_q == StPlay);

endmodule

// File: tb/tb_bird_column.sv
// Directed testbench for bird_column with default parameters
// (ROWS=8, START_ROW=4, FALL_TICKS=2, FLAP_HEIGHT=1).
module tb_bird_column;

  logic       clk;
  logic       reset;
  logic       flap;
  logic       tick;
  logic [7:0] pipe_mask;
  logic [7:0] lit;
  logic [2:0] row;
  logic       crashed;
  logic       playing;

  int n_vec;
  int n_bad;

  bird_column #(
    .ROWS       (8),
    .START_ROW  (4),
    .FALL_TICKS (2),
    .FLAP_HEIGHT(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flap_i     (flap),
    .tick_i     (tick),
    .pipe_mask_i(pipe_mask),
    .lit_o      (lit),
    .row_o      (row),
    .crashed_o  (crashed),
    .playing_o  (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic f, input logic t, input logic [7:0] m);
    reset     = r;
    flap      = f;
    tick      = t;
    pipe_mask = m;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flap  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic check_all(input string tag, input logic [2:0] r, input logic [7:0] l,
                           input logic c, input logic p);
    check_eq({tag, ".row"}, 32'(row), 32'(r));
    check_eq({tag, ".lit"}, 32'(lit), 32'(l));
    check_eq({tag, ".crashed"}, 32'(crashed), 32'(c));
    check_eq({tag, ".playing"}, 32'(playing), 32'(p));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0; flap = 1'b0; tick = 1'b0; pipe_mask = 8'h00;
    @(negedge clk);

    // 1: reset, flap, gravity
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_all("t1_reset", 3'd4, 8'h10, 1'b0, 1'b0);
    ticks(3);
    check_eq("t1_idle_tick_hold", 32'(row), 32'd4);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_all("t1_flap", 3'd5, 8'h20, 1'b0, 1'b1);
    ticks(4);
    check_all("t1_4ticks", 3'd3, 8'h08, 1'b0, 1'b1);

    // 2: fall to floor and crash
    ticks(4);
    check_eq("t2_row1", 32'(row), 32'd1);
    ticks(2);
    check_all("t2_row0", 3'd0, 8'h01, 1'b0, 1'b1);
    ticks(1);
    check_eq("t2_tick3_alive", 32'(crashed), 32'd0);
    ticks(1);
    check_all("t2_floor_crash", 3'd0, 8'h01, 1'b1, 1'b0);
    ticks(3);
    check_eq("t2_dead_freeze", 32'(row), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_all("t2_restart", 3'd4, 8'h10, 1'b0, 1'b0);

    // 3: flap+tick same cycle discards tick and clears fall_cnt
    step(1'b0, 1'b1, 1'b0, 8'h00);
    ticks(1);
    check_eq("t3_row5", 32'(row), 32'd5);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check_eq("t3_flap_tick", 32'(row), 32'd6);
    ticks(1);
    check_eq("t3_next_tick", 32'(row), 32'd6);

    // 4: pipe collision beats flap
    ticks(5);
    check_eq("t4_row3", 32'(row), 32'd3);
    step(1'b0, 1'b1, 1'b0, 8'h08);
    check_all("t4_pipe", 3'd3, 8'h08, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_all("t4_dead_hold", 3'd3, 8'h08, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h08);
    check_all("t4_restart", 3'd4, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h10);
    check_all("t4_idle_ignores_pipe", 3'd4, 8'h10, 1'b0, 1'b0);

    // 5: flap at top row
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_all("t5_row7", 3'd7, 8'h80, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef BIRD_CEILING_CRASH_EN
    check_all("t5_ceiling", 3'd7, 8'h80, 1'b1, 1'b0);
`else
    check_all("t5_ceiling", 3'd7, 8'h80, 1'b0, 1'b1);
`endif

    // 6: reset mid-game overrides flap and tick
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    ticks(6);
    check_all("t6_row2", 3'd2, 8'h04, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_all("t6_reset", 3'd4, 8'h10, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bird_column.md
Name: bird_column

Overview:
Parameterised bird-position engine for the LED-matrix game. It replaces per-cell bird lights with a single column controller that tracks the bird row, applies flap lift and tick-paced gravity, and detects floor and pipe collisions. It drives a one-hot lit vector to the display column and a crash flag to the game controller.

Parameters:
ROWS, 8, number of rows in the bird column (>=2); row 0 = bottom, ROWS-1 = top
START_ROW, 4, bird row after reset / restart (< ROWS)
FALL_TICKS, 2, tick pulses per one-row gravity drop (>=1)
FLAP_HEIGHT, 1, rows gained per flap (1..ROWS-1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
flap  input  1  single-cycle flap pulse, already debounced and edge-detected upstream
tick  input  1  single-cycle game-tick pulse
pipe_mask  input  ROWS  pipe occupancy of the bird column, bit i = row i
lit  output  ROWS  one-hot bird position, bit row = 1
row  output  $clog2(ROWS)  registered bird row index
crashed  output  1  high while in DEAD
playing  output  1  high while in PLAY

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, row=START_ROW, fall_cnt=0, crashed=0, playing=0, lit=1<<START_ROW. Reset overrides all inputs, including mid-game.
- All outputs are registered or decoded purely from registers; input effects are visible one cycle after the sampling edge.
- States: IDLE, PLAY, DEAD.
- IDLE:
  - tick and pipe_mask are ignored; row holds.
  - flap -> PLAY, row = min(row+FLAP_HEIGHT, ROWS-1), fall_cnt=0.
- PLAY, evaluated each cycle in this priority order:
  1. Collision: pipe_mask[row]==1 (current registered row) -> DEAD. Row holds; flap and tick are ignored that cycle.
  2. flap: row = min(row+FLAP_HEIGHT, ROWS-1), fall_cnt=0. A tick in the same cycle is discarded.
  3. tick with fall_cnt < FALL_TICKS-1: fall_cnt++.
  4. tick with fall_cnt == FALL_TICKS-1: fall_cnt=0. If row>0, row--. If row==0, floor crash -> DEAD with row held at 0.
  - Saturation at the top is a silent clamp (no crash) unless the optional feature is enabled.
- DEAD:
  - row, lit, and fall_cnt freeze; crashed=1.
  - tick and pipe_mask are ignored.
  - flap -> IDLE, row=START_ROW, fall_cnt=0, crashed=0.
- playing = (state==PLAY); crashed = (state==DEAD).
- lit is always exactly one-hot and never all zero.
- Row arithmetic uses $clog2(ROWS)+1 bits internally so the sum cannot wrap before clamping.
- FALL_TICKS=1: every tick drops one row.

Optional Feature:
Macro BIRD_CEILING_CRASH_EN.
- Defined: in PLAY, a flap where row+FLAP_HEIGHT > ROWS-1 sets row=ROWS-1 and transitions to DEAD on the same edge. The flap in IDLE still clamps silently.
- Undefined: top-of-column flaps clamp at ROWS-1 and play continues.

Test Plan:
1. Reset, then flap; wait 4 ticks with pipe_mask=0 -> after reset row=4, lit=8'h10. After the flap row=5, playing=1. After 4 ticks row=3.
2. In PLAY at row=1, fall_cnt=0, pulse 4 ticks, pipe_mask=0 -> row=0 after tick 2. On tick 4 crashed=1, row=0, lit=8'h01. Flap -> IDLE, row=4, crashed=0.
3. In PLAY at row=5, fall_cnt=1, assert flap and tick in the same cycle -> row=6, fall_cnt=0. The next single tick leaves row=6.
4. In PLAY at row=3, set pipe_mask=8'h08 with a simultaneous flap -> next cycle crashed=1, row=3. Further flap/tick have no effect until the flap that restarts.
5. In PLAY at row=7, flap -> undefined: row=7, playing=1. Defined BIRD_CEILING_CRASH_EN: crashed=1, row=7.
6. Mid-game at row=2, assert reset with flap=1 and tick=1 -> state IDLE, row=4, lit=8'h10, crashed=0, playing=0.
